// File: rtl/dmem_dump_engine.sv
// dmem_dump_engine: reads a contiguous window of data memory through a
// synchronous-read port and streams the words out over valid/ready.
// The core is held (core_hold) for the whole dump so memory cannot change.
//
// Handshake: a stream word transfers on a posedge where out_valid && out_ready.
// Once out_valid is high, out_data/out_index stay stable until that transfer.
// Reads have one cycle of latency. A 2-entry FIFO holds the returned words.
// A read is issued only when the FIFO has room for it, counting reads still
// in flight.
module dmem_dump_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              core_hold,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_index,
  output logic [1:0]        dbg_state
);

  localparam int CW = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   accepted_q, accepted_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] fifo_mem_q [2];
  logic [DATA_W-1:0] fifo_mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] issue_addr;

  // Output decode, handshake and read-issue decision.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    core_hold  = busy;
    out_valid  = (fifo_cnt_q != 2'd0);
    out_data   = fifo_mem_q[rd_ptr_q];
    out_index  = accepted_q;
    dbg_state  = state_q;
    pop        = out_valid && out_ready;
    push       = inflight_q;
    // Slots already claimed once this cycle's pop has been taken out.
    occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue_addr = base_q + issued_q[ADDR_W-1:0];
    mem_re     = (state_q == ST_RUN) && (issued_q < count_q) && (occ < 3'd2);
    mem_addr   = mem_re ? issue_addr : last_addr_q;
  end

  // Next-state logic for the FSM, counters and return FIFO.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    last_addr_d = last_addr_q;
    inflight_d  = mem_re;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          issued_d   = '0;
          accepted_d = '0;
          state_d    = (word_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_re) begin
          issued_d    = issued_q + CW'(1);
          last_addr_d = issue_addr;
        end
        if (pop) begin
          accepted_d = accepted_q + CW'(1);
          if (accepted_q + CW'(1) == count_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The read issued last cycle returns now; capture it at this edge.
    if (push) begin
      fifo_mem_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // State registers; reset aborts any dump, flushes the FIFO, drops the in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      inflight_q    <= 1'b0;
      last_addr_q   <= '0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      accepted_q    <= accepted_d;
      inflight_q    <= inflight_d;
      last_addr_q   <= last_addr_d;
      fifo_mem_q[0] <= fifo_mem_d[0];
      fifo_mem_q[1] <= fifo_mem_d[1];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_dump_engine.sv
// Bench for dmem_dump_engine: dmem model, ready driver, scoreboard of
// expected words/addresses per dump, and hand-computed timing checks.
module tb_dmem_dump_engine;

  localparam int AW = 8;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy, done, core_hold, mem_re, out_valid, out_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_data;
  logic [AW:0]   out_index;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  dmem_dump_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .core_hold(core_hold),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .dbg_state(dbg_state)
  );

  // Synchronous-read data memory.
  logic [DW-1:0] dmem [256];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   exp_idx_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int tests = 0;
  int fails = 0;
  int outstanding = 0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW:0]   prev_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Compare process: every cycle, outputs against the expected queues.
  always @(negedge clk) begin : cmp
    bit pop;
    if (rst) begin
      exp_q.delete();
      exp_idx_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      pop = out_valid && out_ready;
      if (mem_re) begin
        if (exp_addr_q.size() == 0) flag("mem_re_unexpected");
        else check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
        check("outstanding_lt2", 64'((outstanding - int'(pop)) < 2), 64'(1));
      end
      if (prev_stall)
        check("stall_hold", {out_valid, out_index, out_data}, {1'b1, prev_idx, prev_data});
      if (out_valid) begin
        if (exp_q.size() == 0) flag("out_valid_unexpected");
        else begin
          check("out_data", 64'(out_data), 64'(exp_q[0]));
          check("out_index", 64'(out_index), 64'(exp_idx_q[0]));
          if (pop) begin
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
          end
        end
      end
      if (done) check("done_drained", 64'(exp_q.size() + exp_addr_q.size()), 64'(0));
      outstanding = outstanding + int'(mem_re) - int'(pop);
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      prev_idx    = out_index;
    end
  end

  // ---------------- driver tasks ----------------
  int ready_mode = 0;
  int pat_i = 0;
  logic [5:0] pat = 6'b101001;  // 1,0,0,1,0,1 from bit 0 upward

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[pat_i % 6];
          pat_i++;
        end
      endcase
    end
  end

  // Pulse start for one cycle; when accepted, load the expected dump.
  task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] n, input bit accept);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    if (accept) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + AW'(i);
        exp_q.push_back(dmem[a]);
        exp_idx_q.push_back((AW+1)'(i));
        exp_addr_q.push_back(a);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) flag("done_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_core_hold"}, 64'(core_hold), 64'(0));
    check({tag, "_mem_re"}, 64'(mem_re), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_index"}, 64'(out_index), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [AW-1:0] b;
    logic [AW:0]   n;
    logic [AW-1:0] a;
    bit seen;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;
    for (int i = 0; i < 20; i++) dmem[20 + i] = DW'(i + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: 20 words at full rate, cycle-exact timing.
    ready_mode = 0;
    issue_start(8'd20, 9'd20, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      check("t1_busy", 64'(busy), 64'(c <= 23));
      check("t1_core_hold", 64'(core_hold), 64'(c <= 23));
      check("t1_mem_re", 64'(mem_re), 64'(c <= 20));
      check("t1_out_valid", 64'(out_valid), 64'(c >= 3 && c <= 22));
      check("t1_done", 64'(done), 64'(c == 23));
      if (c >= 3 && c <= 22) begin
        check("t1_out_data", 64'(out_data), 64'(c - 2));
        check("t1_out_index", 64'(out_index), 64'(c - 3));
      end
      if (c < 24) @(posedge clk);
    end

    // Test 2: backpressure pattern 1,0,0,1,0,1 on a 3-word dump.
    dmem[5] = 32'h51C06460; dmem[6] = 32'hDEC287D9; dmem[7] = 32'h6C896594;
    pat_i = 0;
    ready_mode = 2;
    issue_start(8'd5, 9'd3, 1'b1);
    wait_done(60);
    ready_mode = 0;

    // Test 3: address wrap past the top of memory.
    issue_start(8'd254, 9'd4, 1'b1);
    wait_done(40);

    // Test 4: zero-length dump.
    issue_start(8'd10, 9'd0, 1'b1);
    @(negedge clk);
    check("t4_busy", 64'(busy), 64'(1));
    check("t4_done", 64'(done), 64'(1));
    check("t4_core_hold", 64'(core_hold), 64'(1));
    check("t4_mem_re", 64'(mem_re), 64'(0));
    check("t4_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("t4_busy_after", 64'(busy), 64'(0));
    check("t4_done_after", 64'(done), 64'(0));

    // Test 5: reset right after the second word is accepted, then a fresh dump.
    issue_start(8'd100, 9'd10, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_index == 9'd1) seen = 1'b1;
    end
    if (!seen) flag("t5_second_word_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_abort");
    issue_start(8'd100, 9'd10, 1'b1);
    wait_done(60);

    // start together with rst is ignored.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; base_addr = 8'd3; word_count = 9'd5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'(0));
    check("rst_start_mem_re", 64'(mem_re), 64'(0));

    // Test 6: start re-pulsed during RUN is ignored.
    issue_start(8'd30, 9'd10, 1'b1);
    repeat (2) @(posedge clk);
    issue_start(8'd0, 9'd5, 1'b0);
    wait_done(60);

    // Randomized dumps with random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      b = AW'($urandom_range(0, 255));
      n = (AW+1)'($urandom_range(0, 24));
      for (int i = 0; i < int'(n); i++) begin
        a = b + AW'(i);
        dmem[a] = $urandom;
      end
      issue_start(b, n, 1'b1);
      wait_done(300);
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_queues_empty", 64'(exp_q.size() + exp_addr_q.size()), 64'(0));
    check("final_idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_dump_engine.md
Name: dmem_dump_engine

Overview:
- Hardware reader that unloads a contiguous window of data memory after a program run and streams it out word by word over a valid/ready interface.
- It is the counterpart of the bench-side memory preload/readback path: the core writes results into dmem, and this block reads them out in hardware.
- Sits beside the core's data memory on a second, synchronous-read port.
- Asserts core_hold while active so the core cannot modify memory mid-dump.

Parameters:
ADDR_W, 8, dmem word-address width (memory depth 2^ADDR_W words)
DATA_W, 32, data word width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  dump request, sampled on posedge clk while idle
base_addr  in  ADDR_W  first word address, latched on accepted start
word_count  in  ADDR_W+1  number of words to dump (0 .. 2^ADDR_W), latched on accepted start
busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive
done  out  1  one-cycle pulse when the last word has been accepted
core_hold  out  1  equal to busy; core stalls its PC and memory writes while high
mem_re  out  1  dmem read enable
mem_addr  out  ADDR_W  dmem word address
mem_rdata  in  DATA_W  dmem read data, valid exactly 1 cycle after mem_re
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts the word when out_valid && out_ready at posedge
out_data  out  DATA_W  stream word
out_index  out  ADDR_W+1  0-based index of out_data within the dump

Behaviour:
- Reset values: busy=0, done=0, core_hold=0, mem_re=0, mem_addr=0, out_valid=0, out_data=0, out_index=0. Reset mid-dump aborts immediately:
  - FIFO is flushed.
  - The in-flight read is discarded.
  - FSM goes to IDLE.
  - No done pulse is generated.
- FSM states:
  - IDLE: start accepted only here; start during RUN or DONE is ignored. On start with word_count != 0, go to RUN. On start with word_count == 0, go directly to DONE and issue no reads.
  - RUN: issue reads and stream words. Move to DONE on the posedge where the accept count reaches word_count.
  - DONE: one cycle with done=1 and busy=1, then return to IDLE.
- Read issue (RUN only):
  - mem_re=1 when issued < word_count and (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready.
  - mem_addr = base_addr + issued, taken modulo 2^ADDR_W; the address wraps past the top of memory.
  - mem_re=0 with mem_addr held otherwise.
- Return path:
  - The data of a read issued in cycle k is captured into a 2-entry FIFO at the posedge ending cycle k+1.
  - The FIFO never overflows by construction; an overflow is a verification error.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_index = count of previously accepted words.
  - Words are emitted strictly in address order.
  - While out_valid=1 and out_ready=0, out_data and out_index hold stable.
- Latency, with out_ready held at 1 and start accepted at edge E0:
  - mem_re is high in cycles 1..N.
  - out_valid is high in cycles 3..N+2.
  - done pulses in cycle N+3.
  - Throughput is 1 word per cycle.
- Backpressure:
  - Reads stall while FIFO occupancy plus in-flight reads reaches 2.
  - No word is lost or duplicated.
- Simultaneous events:
  - A FIFO push and pop in the same cycle leave occupancy unchanged.
  - In DONE, start is ignored.
  - start in the same cycle as rst is ignored.

Test Plan:
- Preload dmem[20..39] = 1..20; start with base=20, count=20, out_ready=1 -> out_data 1..20 with out_index 0..19 on consecutive cycles 3..22; done in cycle 23; core_hold high cycles 1..23.
- base=5, count=3, dmem[5..7] = 0x51C06460, 0xDEC287D9, 0x6C896594; out_ready toggling 1,0,0,1,0,1 -> exactly those 3 words in order; outputs stable during stalls; mem_re never issues with 2 words outstanding.
- base=254, count=4 with ADDR_W=8 -> mem_addr sequence 254, 255, 0, 1; out_data matches those locations.
- count=0 -> done and busy high for exactly one cycle, 1 cycle after start; mem_re and out_valid never asserted.
- rst asserted in the cycle after word 2 of a 10-word dump is accepted -> next cycle all outputs at reset values; a fresh start then dumps from index 0 correctly.
- start re-pulsed during RUN with base=0 -> ignored; the original dump completes unchanged.
